cmd_fifo_arbiter: RTL and testbench

//  Shares the write port of the 179-bit dual-clock command FIFO (FIFO_HS_CMD) between
//  NUM_REQ requesters, e.g. instruction fetch and data LSU. Each requester uses a

---
 rtl/cmd_fifo_arbiter.sv | 126 ++++++++++++
 tb/tb_cmd_fifo_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fifo_arbiter.sv
`default_nettype none
// cmd_fifo_arbiter: round-robin, command-locked arbiter driving the FIFO_HS_CMD write port.
// Rev 1.0 - initial release.
module cmd_fifo_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int CMD_W   = 179,
  parameter  int CNT_W   = 32,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*CMD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [CMD_W-1:0]         fifo_data,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         beat_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_r;
  logic               out_vld;
  logic [CMD_W-1:0]   out_data;
  logic [CNT_W-1:0]   cnt_r;

  logic               can_load;
  logic               found;
  logic               accept;
  logic               sel_last;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    sel;
  logic [ID_W:0]      idx;
  logic [CMD_W-1:0]   sel_data;
  logic [CMD_W-1:0]   beats [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign beats[i] = req_data[i*CMD_W +: CMD_W];
  end

  // Write strobe is combinational on Full so the FIFO never sees a write while full.
  assign fifo_wr_en = out_vld & ~fifo_full;
  assign can_load   = ~out_vld | fifo_wr_en;

  // Descending scan so the smallest offset from rr_ptr is the one that sticks.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  assign sel      = (state == LOCKED) ? grant_r : pick;
  assign sel_data = beats[sel];
  assign sel_last = req_last[sel];

  // While locked, ready depends only on the lock and the output stage.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED)
      req_ready[grant_r] = can_load;
    else if (can_load && found)
      req_ready[pick] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_r  <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      cnt_r    <= '0;
    end else begin
      if (fifo_wr_en)
        cnt_r <= cnt_r + 1'b1;

      if (accept) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
      end else if (fifo_wr_en) begin
        out_vld  <= 1'b0;
      end

      if (accept) begin
        grant_r <= sel;
        if (sel_last) begin
          state  <= IDLE;
          rr_ptr <= next_id(sel);
        end else begin
          state  <= LOCKED;
        end
      end
    end
  end

  assign fifo_data = out_data;
  assign grant_id  = grant_r;
  assign beat_cnt  = cnt_r;
  assign busy      = (state == LOCKED) | out_vld;

endmodule
`default_nettype wire

// File: tb/tb_cmd_fifo_arbiter.sv
`default_nettype none
// tb_cmd_fifo_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Rev 1.0 - initial release.
module tb_cmd_fifo_arbiter;
  localparam int N  = 2;
  localparam int W  = 179;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     fifo_data;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic [0:0]       grant_id;
  logic             busy;
  logic [CW-1:0]    beat_cnt;

  always #5 clk = ~clk;

  cmd_fifo_arbiter #(.NUM_REQ(N), .CMD_W(W), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: lock owner (-1 = none), round-robin start, one held beat.
  int         m_owner, m_rr, m_gid, m_cnt;
  bit         m_vld;
  logic [W-1:0] m_data;
  int         seq [N];

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_gid = 0; m_cnt = 0; m_vld = 0; m_data = '0;
  endtask

  task automatic set_beat(input int i, input logic [W-1:0] d, input bit last);
    req_data[i*W +: W] = d;
    req_last[i]        = last;
  endtask

  task automatic new_beat(input int i);
    seq[i]++;
    set_beat(i, W'({8'(i), 16'(seq[i]), 32'($urandom)}), $urandom_range(0, 2) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called just after a negedge with inputs set; checks, advances model, returns at next negedge.
  task automatic tick(output int acc);
    logic [N-1:0] er;
    bit cl, ew;
    #1;
    cl = !m_vld || !fifo_full;
    ew = m_vld && !fifo_full;
    er = '0;
    if (m_owner >= 0) begin
      if (cl) er[m_owner] = 1'b1;
    end else if (cl) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (req_valid[j]) begin
          er[j] = 1'b1;
          break;
        end
      end
    end
    chk("ready", W'(req_ready), W'(er));
    chk("wr_en", W'(fifo_wr_en), W'(ew));
    chk("data",  fifo_data, m_data);
    chk("cnt",   W'(beat_cnt), W'(m_cnt));
    chk("busy",  W'(busy), W'(m_owner >= 0 || m_vld));
    chk("gid",   W'(grant_id), W'(m_gid));
    acc = -1;
    for (int j = 0; j < N; j++)
      if (er[j] && req_valid[j]) acc = j;
    if (ew) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_vld = 0;
    end
    if (acc >= 0) begin
      m_vld  = 1;
      m_data = req_data[acc*W +: W];
      m_gid  = acc;
      if (req_last[acc]) begin
        m_owner = -1;
        m_rr    = (acc + 1) % N;
      end else begin
        m_owner = acc;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int a;
    logic [CW-1:0] c0;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    model_reset();
    do_reset();

    #1;
    chk("rst_ready", W'(req_ready), '0);
    chk("rst_wr",    W'(fifo_wr_en), '0);
    chk("rst_data",  fifo_data, '0);
    chk("rst_busy",  W'(busy), '0);
    chk("rst_gid",   W'(grant_id), '0);
    chk("rst_cnt",   W'(beat_cnt), '0);

    // Single-beat command from requester 0.
    set_beat(0, W'('hA5), 1'b1);
    req_valid = 2'b01;
    #1 chk("t1_ready", W'(req_ready), W'(2'b01));
    tick(a);
    req_valid = '0;
    #1;
    chk("t1_wr", W'(fifo_wr_en), W'(1));
    chk("t1_data", fifo_data, W'('hA5));
    tick(a);
    chk("t1_cnt", W'(beat_cnt), W'(1));

    // Both requesters streaming single-beat commands alternate.
    do_reset();
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_beat(0, W'('h200 + k), 1'b1);
      set_beat(1, W'('h300 + k), 1'b1);
      if (k > 0) #1 chk("t2_wr", W'(fifo_wr_en), W'(1));
      tick(a);
      chk("t2_order", W'(a), W'(k % 2));
    end
    req_valid = '0;
    tick(a); tick(a);

    // Four-beat command from requester 1 holds off requester 0.
    do_reset();
    req_valid = 2'b10;
    set_beat(1, W'('h100), 1'b0);
    tick(a);
    chk("t3_first", W'(a), W'(1));
    req_valid = 2'b11;
    set_beat(0, W'('h0F), 1'b1);
    for (int b = 1; b < 4; b++) begin
      set_beat(1, W'('h100 + b), b == 3);
      #1 chk("t3_r0_blocked", W'(req_ready[0]), '0);
      tick(a);
      chk("t3_beat", W'(a), W'(1));
    end
    tick(a);
    chk("t3_then_r0", W'(a), W'(0));
    req_valid = '0;
    tick(a); tick(a);

    // Backpressure holds the output beat and blocks all requesters.
    do_reset();
    set_beat(0, W'('hBEEF), 1'b1);
    req_valid = 2'b01;
    tick(a);
    fifo_full = 1'b1;
    set_beat(0, W'('hCAFE), 1'b1);
    set_beat(1, W'('hD00D), 1'b1);
    req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_wr", W'(fifo_wr_en), '0);
      chk("t4_data", fifo_data, W'('hBEEF));
      chk("t4_ready", W'(req_ready), '0);
      tick(a);
    end
    c0 = beat_cnt;
    fifo_full = 1'b0;
    #1;
    chk("t4_held_wr", W'(fifo_wr_en), W'(1));
    chk("t4_held_data", fifo_data, W'('hBEEF));
    tick(a);
    chk("t4_cnt", W'(beat_cnt), W'(c0 + 8'd1));
    req_valid = '0;
    tick(a); tick(a);

    // Reset in the middle of a command.
    do_reset();
    req_valid = 2'b01;
    set_beat(0, W'('h500), 1'b0);
    tick(a);
    set_beat(0, W'('h501), 1'b0);
    tick(a);
    do_reset();
    req_valid = '0;
    #1;
    chk("t5_busy", W'(busy), '0);
    chk("t5_wr", W'(fifo_wr_en), '0);
    req_valid = 2'b10;
    set_beat(1, W'('h600), 1'b1);
    #1 chk("t5_ready", W'(req_ready), W'(2'b10));
    tick(a);
    chk("t5_grant", W'(a), W'(1));
    req_valid = '0;
    tick(a);
    chk("t5_gid", W'(grant_id), W'(1));
    tick(a);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < N; i++) new_beat(i);
    for (int c = 0; c < 10000; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 6);
      tick(a);
      if (a >= 0) new_beat(a);
    end
    fifo_full = 1'b0;
    req_valid = '0;
    tick(a); tick(a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
